// File: rtl/accum_cache_downstream.sv
// Direct-mapped write-back cache that keeps a running total per client and returns it.
// Build macro SATURATE_EN: clamp sums at all-ones and flag rsp_sat; otherwise sums wrap.
module accum_cache_downstream #(
    parameter int CLIENT_W = 8,
    parameter int DATA_W   = 32,
    parameter int LINES    = 4,
    parameter int WORDS    = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_rw,
    input  logic [CLIENT_W-1:0]               req_client,
    input  logic [DATA_W-1:0]                 req_data,
    output logic                              rsp_valid,
    output logic [DATA_W-1:0]                 rsp_data,
    output logic                              rsp_sat,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic                              mem_req_rw,
    output logic [CLIENT_W-$clog2(WORDS)-1:0] mem_req_addr,
    output logic [DATA_W*WORDS-1:0]           mem_req_wdata,
    input  logic                              mem_rsp_valid,
    input  logic [DATA_W*WORDS-1:0]           mem_rsp_data
);

    localparam int WORD_W  = $clog2(WORDS);
    localparam int IDX_W   = $clog2(LINES);
    localparam int TAG_W   = CLIENT_W - WORD_W - IDX_W;
    localparam int LADDR_W = CLIENT_W - WORD_W;
    localparam int LINE_W  = DATA_W * WORDS;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COMPARE   = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_ALLOCATE  = 3'd3,
        ST_FILL_WAIT = 3'd4
    } state_t;

    state_t               state_r;
    logic                 req_ready_r;
    logic                 rsp_valid_r;
    logic [DATA_W-1:0]    rsp_data_r;
    logic                 rsp_sat_r;
    logic                 mem_req_valid_r;
    logic                 mem_req_rw_r;
    logic [LADDR_W-1:0]   mem_req_addr_r;
    logic [LINE_W-1:0]    mem_req_wdata_r;

    logic [LINES-1:0]     valid_r;
    logic [LINES-1:0]     dirty_r;
    logic [TAG_W-1:0]     tag_mem_r  [LINES];
    logic [LINE_W-1:0]    data_mem_r [LINES];

    logic                 cap_rw_r;
    logic [CLIENT_W-1:0]  cap_client_r;
    logic [DATA_W-1:0]    cap_data_r;

    logic [WORD_W-1:0]    cap_word_s;
    logic [IDX_W-1:0]     cap_idx_s;
    logic [TAG_W-1:0]     cap_tag_s;
    logic [LADDR_W-1:0]   cap_line_addr_s;
    logic [LADDR_W-1:0]   victim_addr_s;
    logic [LINE_W-1:0]    cur_line_s;
    logic [DATA_W-1:0]    cur_word_s;
    logic                 hit_s;
    logic [DATA_W-1:0]    sum_word_s;
    logic                 sat_s;
    logic                 accept_s;
    logic                 fill_en_s;
    logic                 acc_wr_en_s;

    assign req_ready     = req_ready_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_data      = rsp_data_r;
    assign rsp_sat       = rsp_sat_r;
    assign mem_req_valid = mem_req_valid_r;
    assign mem_req_rw    = mem_req_rw_r;
    assign mem_req_addr  = mem_req_addr_r;
    assign mem_req_wdata = mem_req_wdata_r;

    assign accept_s    = req_valid && req_ready_r;
    assign fill_en_s   = (state_r == ST_FILL_WAIT) && mem_rsp_valid;
    assign acc_wr_en_s = (state_r == ST_COMPARE) && hit_s && cap_rw_r;

    // Address split of the captured client and lookup of its line and word.
    always_comb begin
        cap_word_s      = cap_client_r[WORD_W-1:0];
        cap_idx_s       = cap_client_r[WORD_W +: IDX_W];
        cap_tag_s       = cap_client_r[CLIENT_W-1 -: TAG_W];
        cap_line_addr_s = cap_client_r[CLIENT_W-1:WORD_W];
        victim_addr_s   = {tag_mem_r[cap_idx_s], cap_idx_s};
        hit_s           = valid_r[cap_idx_s] && (tag_mem_r[cap_idx_s] == cap_tag_s);
        cur_line_s      = data_mem_r[cap_idx_s];
        cur_word_s      = cur_line_s[DATA_W*int'(cap_word_s) +: DATA_W];
    end

`ifdef SATURATE_EN
    logic [DATA_W:0] sum_wide_s;

    // Widened add; a carry out clamps the total and raises the saturation flag.
    always_comb begin
        sum_wide_s = {1'b0, cur_word_s} + {1'b0, cap_data_r};
        if (sum_wide_s[DATA_W]) begin
            sum_word_s = '1;
            sat_s      = 1'b1;
        end else begin
            sum_word_s = sum_wide_s[DATA_W-1:0];
            sat_s      = 1'b0;
        end
    end
`else
    // Wrapping add: the carry out of the top bit is simply dropped.
    always_comb begin
        sum_word_s = cur_word_s + cap_data_r;
        sat_s      = 1'b0;
    end
`endif

    // Request capture; later states work only from this copy.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            cap_rw_r     <= req_rw;
            cap_client_r <= req_client;
            cap_data_r   <= req_data;
        end
    end

    // Data and tag storage, never cleared: valid_r qualifies every entry.
    always_ff @(posedge clk) begin
        if (fill_en_s) begin
            data_mem_r[cap_idx_s] <= mem_rsp_data;
            tag_mem_r[cap_idx_s]  <= cap_tag_s;
        end else if (acc_wr_en_s) begin
            data_mem_r[cap_idx_s][DATA_W*int'(cap_word_s) +: DATA_W] <= sum_word_s;
        end
    end

    // Control FSM with registered handshake, response and memory-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            req_ready_r     <= 1'b1;
            rsp_valid_r     <= 1'b0;
            rsp_data_r      <= '0;
            rsp_sat_r       <= 1'b0;
            mem_req_valid_r <= 1'b0;
            mem_req_rw_r    <= 1'b0;
            mem_req_addr_r  <= '0;
            mem_req_wdata_r <= '0;
            valid_r         <= '0;
            dirty_r         <= '0;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        req_ready_r <= 1'b0;
                        state_r     <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (hit_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= cap_rw_r ? sum_word_s : cur_word_s;
                        rsp_sat_r   <= cap_rw_r & sat_s;
                        if (cap_rw_r) begin
                            dirty_r[cap_idx_s] <= 1'b1;
                        end
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else if (valid_r[cap_idx_s] && dirty_r[cap_idx_s]) begin
                        mem_req_valid_r <= 1'b1;
                        mem_req_rw_r    <= 1'b1;
                        mem_req_addr_r  <= victim_addr_s;
                        mem_req_wdata_r <= cur_line_s;
                        state_r         <= ST_WRITEBACK;
                    end else begin
                        mem_req_valid_r <= 1'b1;
                        mem_req_rw_r    <= 1'b0;
                        mem_req_addr_r  <= cap_line_addr_s;
                        mem_req_wdata_r <= '0;
                        state_r         <= ST_ALLOCATE;
                    end
                end
                ST_WRITEBACK: begin
                    // Victim accepted: turn the held request straight into the line read.
                    if (mem_req_ready) begin
                        mem_req_rw_r    <= 1'b0;
                        mem_req_addr_r  <= cap_line_addr_s;
                        mem_req_wdata_r <= '0;
                        state_r         <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_req_ready) begin
                        mem_req_valid_r <= 1'b0;
                        state_r         <= ST_FILL_WAIT;
                    end
                end
                ST_FILL_WAIT: begin
                    if (mem_rsp_valid) begin
                        valid_r[cap_idx_s] <= 1'b1;
                        dirty_r[cap_idx_s] <= 1'b0;
                        state_r            <= ST_COMPARE;
                    end
                end
                default: begin
                    req_ready_r     <= 1'b1;
                    mem_req_valid_r <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_cache_downstream.sv
// Directed bench for accum_cache_downstream: a zero-filled backing store model plus scenario tasks.
module tb_accum_cache_downstream;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_rw;
    logic [7:0]    req_client;
    logic [31:0]   req_data;
    logic          rsp_valid;
    logic [31:0]   rsp_data;
    logic          rsp_sat;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic          mem_req_rw;
    logic [5:0]    mem_req_addr;
    logic [127:0]  mem_req_wdata;
    logic          mem_rsp_valid = 1'b0;
    logic [127:0]  mem_rsp_data  = '0;

    int vecs = 0;
    int errs = 0;

    logic [127:0] mem_store [64] = '{default: '0};
    int           wr_count = 0;
    int           rd_count = 0;
    int           ev_seq = 0;
    int           last_wr_seq = 0;
    int           last_rd_seq = 0;
    logic [5:0]   last_wr_addr = '0;
    logic [5:0]   last_rd_addr = '0;
    logic [127:0] last_wr_data = '0;
    bit           rsp_enable = 1'b1;
    int           rd_served = 0;
    int           late_cnt = 0;
    int           late_served = 0;

    accum_cache_downstream dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_client(req_client), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_sat(rsp_sat),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    always #5 clk = ~clk;

    // Backing store: record handshakes as the DUT sees them at the clock edge.
    always @(posedge clk) begin
        if (!rst && mem_req_valid && mem_req_ready) begin
            ev_seq++;
            if (mem_req_rw) begin
                mem_store[mem_req_addr] = mem_req_wdata;
                wr_count++;
                last_wr_addr = mem_req_addr;
                last_wr_data = mem_req_wdata;
                last_wr_seq  = ev_seq;
            end else begin
                rd_count++;
                last_rd_addr = mem_req_addr;
                last_rd_seq  = ev_seq;
            end
        end
    end

    // Read data returns one cycle after the read handshake; a forced stray response is also possible.
    always @(negedge clk) begin
        mem_rsp_valid = 1'b0;
        if (late_cnt != late_served) begin
            late_served   = late_cnt;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = {4{32'hAAAA_AAAA}};
        end else if (rd_count != rd_served) begin
            rd_served = rd_count;
            if (rsp_enable) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_store[last_rd_addr];
            end
        end
    end

    task automatic start_req(input logic rw, input logic [7:0] client, input logic [31:0] data);
        int w = 0;
        @(negedge clk); #1;
        req_valid = 1'b1; req_rw = rw; req_client = client; req_data = data;
        while (!req_ready && w < 100) begin
            @(negedge clk); #1;
            w++;
        end
        vecs++;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL accept_timeout: req_ready=%b expected 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rdata, output logic rsat, output int lat,
                            output int mrsp_lat, output bit saw_mreq);
        bit got = 1'b0;
        rdata = '0; rsat = 1'b0; lat = 0; mrsp_lat = -1; saw_mreq = 1'b0;
        for (int i = 1; i <= 200 && !got; i++) begin
            @(negedge clk); #1;
            if (mem_req_valid) saw_mreq = 1'b1;
            if (mem_rsp_valid && mrsp_lat < 0) mrsp_lat = i;
            if (rsp_valid) begin
                got = 1'b1; lat = i; rdata = rsp_data; rsat = rsp_sat;
            end
        end
        vecs++;
        if (!got) begin errs++; $display("FAIL rsp_timeout: rsp_valid=0 after 200 cycles expected 1"); end
    endtask

    task automatic do_req(input logic rw, input logic [7:0] client, input logic [31:0] data,
                          output logic [31:0] rdata, output logic rsat, output int lat,
                          output int mrsp_lat, output bit saw_mreq);
        start_req(rw, client, data);
        wait_rsp(rdata, rsat, lat, mrsp_lat, saw_mreq);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        vecs++; if (req_ready !== 1'b1)       begin errs++; $display("FAIL rst_req_ready: got %b exp 1", req_ready); end
        vecs++; if (rsp_valid !== 1'b0)       begin errs++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
        vecs++; if (rsp_data !== 32'h0)       begin errs++; $display("FAIL rst_rsp_data: got %h exp 0", rsp_data); end
        vecs++; if (rsp_sat !== 1'b0)         begin errs++; $display("FAIL rst_rsp_sat: got %b exp 0", rsp_sat); end
        vecs++; if (mem_req_valid !== 1'b0)   begin errs++; $display("FAIL rst_mem_valid: got %b exp 0", mem_req_valid); end
        vecs++; if (mem_req_rw !== 1'b0)      begin errs++; $display("FAIL rst_mem_rw: got %b exp 0", mem_req_rw); end
        vecs++; if (mem_req_addr !== 6'h00)   begin errs++; $display("FAIL rst_mem_addr: got %h exp 0", mem_req_addr); end
        vecs++; if (mem_req_wdata !== 128'h0) begin errs++; $display("FAIL rst_mem_wdata: got %h exp 0", mem_req_wdata); end
    endtask

    task automatic test_cold_read;
        logic [31:0] d; logic s; int lat, ml; bit sm;
        int rd0 = rd_count;
        int wr0 = wr_count;
        do_req(1'b0, 8'h05, 32'h0, d, s, lat, ml, sm);
        vecs++; if (d !== 32'h0)             begin errs++; $display("FAIL cold_data: got %h exp 0", d); end
        vecs++; if (rd_count !== rd0 + 1)    begin errs++; $display("FAIL cold_rd_count: got %0d exp %0d", rd_count, rd0 + 1); end
        vecs++; if (last_rd_addr !== 6'h01)  begin errs++; $display("FAIL cold_rd_addr: got %h exp 01", last_rd_addr); end
        vecs++; if (wr_count !== wr0)        begin errs++; $display("FAIL cold_no_write: got %0d exp %0d", wr_count, wr0); end
        vecs++; if (ml < 1 || lat !== ml + 2) begin errs++; $display("FAIL cold_latency: rsp at %0d, mem_rsp at %0d, exp gap 2", lat, ml); end
    endtask

    task automatic test_accum_hit;
        logic [31:0] d; logic s; int lat, ml; bit sm;
        do_req(1'b1, 8'h05, 32'h10, d, s, lat, ml, sm);
        vecs++; if (d !== 32'h10)  begin errs++; $display("FAIL acc1_data: got %h exp 10", d); end
        vecs++; if (s !== 1'b0)    begin errs++; $display("FAIL acc1_sat: got %b exp 0", s); end
        vecs++; if (lat !== 2)     begin errs++; $display("FAIL acc1_latency: got %0d exp 2", lat); end
        do_req(1'b1, 8'h05, 32'h20, d, s, lat, ml, sm);
        vecs++; if (d !== 32'h30)  begin errs++; $display("FAIL acc2_data: got %h exp 30", d); end
        vecs++; if (lat !== 2)     begin errs++; $display("FAIL acc2_latency: got %0d exp 2", lat); end
        vecs++; if (sm !== 1'b0)   begin errs++; $display("FAIL acc2_no_mem: got mem_req_valid seen=%b exp 0", sm); end
        @(negedge clk); #1;
        vecs++; if (rsp_valid !== 1'b0) begin errs++; $display("FAIL acc2_rsp_pulse: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_back_to_back;
        logic exp_b;
        @(negedge clk); #1;
        req_valid = 1'b1; req_rw = 1'b0; req_client = 8'h05; req_data = 32'h0;
        for (int k = 0; k < 7; k++) begin
            if (k == 5) req_valid = 1'b0;
            exp_b = (k % 2 == 0);
            vecs++; if (req_ready !== exp_b) begin errs++; $display("FAIL b2b_ready[%0d]: got %b exp %b", k, req_ready, exp_b); end
            exp_b = (k >= 2) && (k % 2 == 0);
            vecs++; if (rsp_valid !== exp_b) begin errs++; $display("FAIL b2b_rsp_valid[%0d]: got %b exp %b", k, rsp_valid, exp_b); end
            if (exp_b) begin
                vecs++; if (rsp_data !== 32'h30) begin errs++; $display("FAIL b2b_rsp_data[%0d]: got %h exp 30", k, rsp_data); end
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_dirty_evict;
        logic [31:0] d; logic s; int lat, ml; bit sm;
        logic [127:0] wl;
        int rd0 = rd_count;
        int wr0 = wr_count;
        do_req(1'b0, 8'h45, 32'h0, d, s, lat, ml, sm);
        wl = last_wr_data;
        vecs++; if (wr_count !== wr0 + 1)           begin errs++; $display("FAIL evict_wr_count: got %0d exp %0d", wr_count, wr0 + 1); end
        vecs++; if (last_wr_addr !== 6'h01)         begin errs++; $display("FAIL evict_wr_addr: got %h exp 01", last_wr_addr); end
        vecs++; if (wl !== {64'h0, 32'h30, 32'h0})  begin errs++; $display("FAIL evict_wr_data: got %h exp word1=30", wl); end
        vecs++; if (last_rd_addr !== 6'h11)         begin errs++; $display("FAIL evict_rd_addr: got %h exp 11", last_rd_addr); end
        vecs++; if (last_wr_seq >= last_rd_seq)     begin errs++; $display("FAIL evict_order: write seq %0d read seq %0d exp write first", last_wr_seq, last_rd_seq); end
        vecs++; if (d !== 32'h0)                    begin errs++; $display("FAIL evict_data: got %h exp 0", d); end
        do_req(1'b0, 8'h05, 32'h0, d, s, lat, ml, sm);
        vecs++; if (rd_count !== rd0 + 2)           begin errs++; $display("FAIL refetch_rd_count: got %0d exp %0d", rd_count, rd0 + 2); end
        vecs++; if (last_rd_addr !== 6'h01)         begin errs++; $display("FAIL refetch_rd_addr: got %h exp 01", last_rd_addr); end
        vecs++; if (wr_count !== wr0 + 1)           begin errs++; $display("FAIL refetch_clean_victim: got %0d writes exp %0d", wr_count, wr0 + 1); end
        vecs++; if (d !== 32'h30)                   begin errs++; $display("FAIL refetch_data: got %h exp 30", d); end
    endtask

    task automatic test_overflow;
        logic [31:0] d; logic s; int lat, ml; bit sm;
        logic [31:0] exp_d; logic exp_s;
`ifdef SATURATE_EN
        exp_d = 32'hFFFF_FFFF; exp_s = 1'b1;
`else
        exp_d = 32'h0000_0010; exp_s = 1'b0;
`endif
        do_req(1'b1, 8'h05, 32'hFFFF_FFC0, d, s, lat, ml, sm);
        vecs++; if (d !== 32'hFFFF_FFF0) begin errs++; $display("FAIL ovf_setup_data: got %h exp FFFFFFF0", d); end
        vecs++; if (s !== 1'b0)          begin errs++; $display("FAIL ovf_setup_sat: got %b exp 0", s); end
        do_req(1'b1, 8'h05, 32'h20, d, s, lat, ml, sm);
        vecs++; if (d !== exp_d)         begin errs++; $display("FAIL ovf_data: got %h exp %h", d, exp_d); end
        vecs++; if (s !== exp_s)         begin errs++; $display("FAIL ovf_sat: got %b exp %b", s, exp_s); end
    endtask

    task automatic test_backpressure;
        logic [31:0] d; logic s; int lat, ml; bit sm;
        logic [127:0] exp_line = '0;
        int wr0 = wr_count;
        int w = 0;
`ifdef SATURATE_EN
        exp_line[63:32] = 32'hFFFF_FFFF;
`else
        exp_line[63:32] = 32'h0000_0010;
`endif
        mem_req_ready = 1'b0;
        start_req(1'b0, 8'h45, 32'h0);
        while (!mem_req_valid && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        for (int c = 0; c < 10; c++) begin
            vecs++;
            if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b1 || mem_req_addr !== 6'h01 || mem_req_wdata !== exp_line) begin
                errs++;
                $display("FAIL bp_hold[%0d]: got v=%b rw=%b a=%h wd=%h exp v=1 rw=1 a=01 wd=%h",
                         c, mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, exp_line);
            end
            @(negedge clk); #1;
        end
        vecs++; if (wr_count !== wr0) begin errs++; $display("FAIL bp_no_early_write: got %0d exp %0d", wr_count, wr0); end
        mem_req_ready = 1'b1;
        wait_rsp(d, s, lat, ml, sm);
        vecs++; if (wr_count !== wr0 + 1)     begin errs++; $display("FAIL bp_one_write: got %0d exp %0d", wr_count, wr0 + 1); end
        vecs++; if (last_wr_data !== exp_line) begin errs++; $display("FAIL bp_wr_data: got %h exp %h", last_wr_data, exp_line); end
        vecs++; if (last_rd_addr !== 6'h11)   begin errs++; $display("FAIL bp_rd_addr: got %h exp 11", last_rd_addr); end
        vecs++; if (d !== 32'h0)              begin errs++; $display("FAIL bp_data: got %h exp 0", d); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d; logic s; int lat, ml; bit sm;
        bit seen = 1'b0;
        int w = 0;
        int rd0;
        // Reset while a line read is still being offered: the request must drop without a clock edge.
        mem_req_ready = 1'b0;
        start_req(1'b0, 8'h0A, 32'h0);
        while (!mem_req_valid && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        rst = 1'b1;
        #1;
        vecs++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL rstA_mem_valid: got %b exp 0", mem_req_valid); end
        vecs++; if (req_ready !== 1'b1)     begin errs++; $display("FAIL rstA_req_ready: got %b exp 1", req_ready); end
        @(negedge clk); #1;
        rst = 1'b0;
        mem_req_ready = 1'b1;
        // Reset while waiting for read data, then deliver the data late.
        rsp_enable = 1'b0;
        rd0 = rd_count;
        start_req(1'b0, 8'h0A, 32'h0);
        w = 0;
        while (rd_count == rd0 && w < 20) begin
            @(negedge clk); #1;
            w++;
        end
        vecs++; if (rd_count !== rd0 + 1) begin errs++; $display("FAIL rstB_read_issued: got %0d exp %0d", rd_count, rd0 + 1); end
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        vecs++; if (mem_req_valid !== 1'b0) begin errs++; $display("FAIL rstB_mem_valid: got %b exp 0", mem_req_valid); end
        if (rsp_valid) seen = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        late_cnt++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        vecs++; if (seen !== 1'b0) begin errs++; $display("FAIL rstB_no_rsp: got rsp_valid seen=%b exp 0", seen); end
        rsp_enable = 1'b1;
        rd0 = rd_count;
        do_req(1'b0, 8'h0A, 32'h0, d, s, lat, ml, sm);
        vecs++; if (rd_count !== rd0 + 1)    begin errs++; $display("FAIL rstB_miss: got %0d reads exp %0d", rd_count, rd0 + 1); end
        vecs++; if (last_rd_addr !== 6'h02)  begin errs++; $display("FAIL rstB_rd_addr: got %h exp 02", last_rd_addr); end
        vecs++; if (d !== 32'h0)             begin errs++; $display("FAIL rstB_data: got %h exp 0", d); end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_rw = 1'b0; req_client = 8'h00; req_data = 32'h0;
        mem_req_ready = 1'b1;
        test_reset;
        test_cold_read;
        test_accum_hit;
        test_back_to_back;
        test_dirty_evict;
        test_overflow;
        test_backpressure;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
